// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forward-mux selects,
// memory-wait FSM states and the forward-select decode.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'b00,
    MS_WAIT  = 2'b01,
    MS_ABORT = 2'b10
  } mem_state_e;

  // The M stage is younger, so its result wins over W. x0 is never forwarded.
  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                       input logic [4:0] rd_w, input logic we_m,
                                       input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-unit bus: pipeline register ids and enables in, forward/stall/flush out.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, LoadE, PCSrcE;
  logic             MemReqM, MemReadyM, CntClr;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, CntClr,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, CntClr,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCnt
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: Mealy stall while a request is outstanding,
// aborting with a one-cycle error pulse after TIMEOUT stalled cycles.
module mem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);
  localparam int WCW = $clog2(TIMEOUT) + 1;

  mem_state_e     state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MS_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (mem_req && !mem_ready) begin
          // The exit cycle already stalls, so it counts as wait cycle 1.
          state_d   = MS_WAIT;
          wcnt_d    = WCW'(1);
          mem_stall = 1'b1;
        end
      end
      MS_WAIT: begin
        if (mem_ready) begin
          state_d = MS_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (wcnt_q == WCW'(TIMEOUT - 1)) state_d = MS_ABORT;
          else                             wcnt_d  = wcnt_q + 1'b1;
        end
      end
      MS_ABORT: begin
        mem_err = 1'b1;
        state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use and
// branch bubbles, memory-wait freeze and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic        clk,
  input logic        reset_n,
  pipe_ctrl_if.slave bus
);
  logic             mem_stall, mem_err, lw_stall;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_mem_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (bus.MemReqM),
    .mem_ready (bus.MemReadyM),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  assign lw_stall = bus.LoadE && (bus.RdE != 5'd0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      // Freeze everything up to M; a taken branch in E waits for release.
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      flush_w = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      flush_d = bus.PCSrcE;
    end else if (bus.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.CntClr)                    stall_cnt_d = '0;
    else if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.RdW, bus.RegWriteM, bus.RegWriteW);
  assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.RdW, bus.RegWriteM, bus.RegWriteW);
  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.FlushW    = flush_w;
  assign bus.MemErr    = mem_err;
  assign bus.StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs queued at drive time,
// popped and compared mid-cycle.
module tb_pipe_ctrl;
  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_ctrl #(.TIMEOUT(16), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, err;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic wm; logic [4:0] rdm; logic ww; logic [4:0] rdw, rs1, rs2; logic [1:0] fa, fb;
  } fwd_vec_t;

  typedef struct packed {
    logic ld; logic [4:0] rde, rs1, rs2; logic pc; logic [3:0] st; logic [2:0] fl;
  } lw_vec_t;

  obs_t exp_q[$];
  obs_t got, want;
  logic [CW-1:0] exp_cnt = '0;
  int nvec = 0;
  int nerr = 0;

  function automatic obs_t observe();
    obs_t o;
    o.fa = bus.ForwardAE; o.fb = bus.ForwardBE;
    o.sf = bus.StallF; o.sd = bus.StallD; o.se = bus.StallE; o.sm = bus.StallM;
    o.fd = bus.FlushD; o.fe = bus.FlushE; o.fw = bus.FlushW;
    o.err = bus.MemErr; o.cnt = bus.StallCnt;
    return o;
  endfunction

  task automatic clr_in();
    {bus.Rs1D, bus.Rs2D, bus.Rs1E, bus.Rs2E, bus.RdE, bus.RdM, bus.RdW} = '0;
    {bus.RegWriteM, bus.RegWriteW, bus.LoadE, bus.PCSrcE} = '0;
    {bus.MemReqM, bus.MemReadyM, bus.CntClr} = '0;
  endtask

  // Queue one expectation; the counter model advances for the coming edge.
  task automatic push_exp(input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] st,
                          input logic [2:0] fl, input logic err);
    obs_t e;
    e.fa = fa; e.fb = fb;
    {e.sf, e.sd, e.se, e.sm} = st;
    {e.fd, e.fe, e.fw} = fl;
    e.err = err; e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (bus.CntClr)                   exp_cnt = '0;
    else if (st[3] && exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    clr_in();
    reset_n = 1'b0;
    #3;
    push_exp(2'b00, 2'b00, 4'h0, 3'h0, 1'b0);
    #1;
    got = observe(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL reset_idle got %h want %h", got, want); end
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    push_exp(2'b10, 2'b00, 4'h0, 3'h0, 1'b0);
    #1;
    got = observe(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL reset_comb got %h want %h", got, want); end
    clr_in();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    fwd_vec_t tv[7];
    tv[0] = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 2'b10, 2'b00};
    tv[1] = '{1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 2'b00};
    tv[2] = '{1'b1, 5'd3, 1'b1, 5'd4, 5'd3, 5'd4, 2'b10, 2'b01};
    tv[3] = '{1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 2'b01, 2'b01};
    tv[4] = '{1'b1, 5'd9, 1'b0, 5'd9, 5'd9, 5'd9, 2'b10, 2'b10};
    tv[5] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    tv[6] = '{1'b1, 5'd2, 1'b1, 5'd2, 5'd7, 5'd2, 2'b00, 2'b10};
    for (int i = 0; i < 7; i++) begin
      clr_in();
      bus.RegWriteM = tv[i].wm; bus.RdM = tv[i].rdm; bus.RegWriteW = tv[i].ww;
      bus.RdW = tv[i].rdw; bus.Rs1E = tv[i].rs1; bus.Rs2E = tv[i].rs2;
      push_exp(tv[i].fa, tv[i].fb, 4'h0, 3'h0, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL forward[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lwstall();
    lw_vec_t tv[6];
    tv[0] = '{1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 4'b1100, 3'b010};
    tv[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000};
    tv[2] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 4'b1100, 3'b110};
    tv[3] = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 4'b0000, 3'b110};
    tv[4] = '{1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 4'b0000, 3'b000};
    tv[5] = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 4'b0000, 3'b000};
    for (int i = 0; i < 6; i++) begin
      clr_in();
      bus.LoadE = tv[i].ld; bus.RdE = tv[i].rde; bus.Rs1D = tv[i].rs1;
      bus.Rs2D = tv[i].rs2; bus.PCSrcE = tv[i].pc;
      push_exp(2'b00, 2'b00, tv[i].st, tv[i].fl, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL lwstall[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  // Cycle 0: request served at once; cycles 1..4: three wait cycles then ready.
  task automatic test_mem_ready();
    for (int i = 0; i < 6; i++) begin
      clr_in();
      bus.MemReqM   = (i < 5);
      bus.MemReadyM = (i == 0) || (i == 4);
      if (i >= 1 && i <= 3) push_exp(2'b00, 2'b00, 4'hF, 3'b001, 1'b0);
      else                  push_exp(2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL mem_ready[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 18; i++) begin
      clr_in();
      bus.MemReqM = (i < 16);
      if (i < 16)       push_exp(2'b00, 2'b00, 4'hF, 3'b001, 1'b0);
      else if (i == 16) push_exp(2'b00, 2'b00, 4'h0, 3'b000, 1'b1);
      else              push_exp(2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL timeout[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_stall();
    for (int i = 0; i < 4; i++) begin
      clr_in();
      bus.MemReqM = (i < 3); bus.MemReadyM = (i == 2); bus.PCSrcE = (i < 3);
      if (i < 2)       push_exp(2'b00, 2'b00, 4'hF, 3'b001, 1'b0);
      else if (i == 2) push_exp(2'b00, 2'b00, 4'h0, 3'b110, 1'b0);
      else             push_exp(2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL branch_stall[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) begin
      clr_in();
      bus.MemReqM = 1'b1;
      push_exp(2'b00, 2'b00, 4'hF, 3'b001, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL pre_reset[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
    #2;
    clr_in();
    reset_n = 1'b0;
    exp_cnt = '0;
    push_exp(2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
    #1;
    got = observe(); want = exp_q.pop_front(); nvec++;
    if (got !== want) begin nerr++; $display("FAIL async_reset got %h want %h", got, want); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      push_exp(2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL post_reset[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  // Clear while stalling, climb past saturation, then clear again.
  task automatic test_saturate();
    for (int i = 0; i < 72; i++) begin
      clr_in();
      bus.LoadE = 1'b1; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
      bus.CntClr = (i == 0) || (i == 70);
      push_exp(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); nvec++;
      if (got !== want) begin nerr++; $display("FAIL saturate[%0d] got %h want %h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_lwstall();
    test_mem_ready();
    test_timeout();
    test_branch_in_stall();
    test_reset_mid_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
